// File: rtl/mem_port_arbiter_if.sv
// Fetch/data request ports, pipeline stall requests and RAM side of the shared
// single-port memory arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          stall_req_if;
  logic          stall_req_mem;
  logic          ram_ce;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wd;
  logic [DW-1:0] ram_rd;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rd,
    output if_ack, if_rdata, d_ack, d_rdata, stall_req_if, stall_req_mem,
           ram_ce, ram_we, ram_addr, ram_wd
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rd,
    input  if_ack, if_rdata, d_ack, d_rdata, stall_req_if, stall_req_mem,
           ram_ce, ram_we, ram_addr, ram_wd
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the MEM
// stage: one transaction at a time, fixed MEM_LAT access, one-cycle ack.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(MEM_LAT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          lastGrant;   // 1 = data port won the last grant
  logic          owner;       // 1 = data port owns the in-flight transaction
  logic          latWe;
  logic [AW-1:0] latAddr;
  logic [DW-1:0] latWd;
  logic [DW-1:0] ifRdata;
  logic [DW-1:0] dRdata;
  logic          grantD;
  logic          lastCyc;

  // Data wins when alone or when fetch had the previous grant.
  assign grantD  = bus.d_req & (~bus.if_req | ~lastGrant);
  assign lastCyc = (cnt == CW'(MEM_LAT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lastGrant <= 1'b0;
      owner     <= 1'b0;
      latWe     <= 1'b0;
      latAddr   <= '0;
      latWd     <= '0;
      ifRdata   <= '0;
      dRdata    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.if_req | bus.d_req) begin
          state     <= BUSY;
          cnt       <= CW'(1);
          owner     <= grantD;
          lastGrant <= grantD;
          latWe     <= grantD & bus.d_we;
          latAddr   <= grantD ? bus.d_addr : bus.if_addr;
          latWd     <= grantD ? bus.d_wdata : latWd;
        end
        BUSY: if (lastCyc) begin
          state <= ACK;
          cnt   <= '0;
          if (!latWe) begin
            if (owner) dRdata  <= bus.ram_rd;
            else       ifRdata <= bus.ram_rd;
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM address/data come only from the latches, so they hold between accesses.
  assign bus.ram_ce   = (state == BUSY);
  assign bus.ram_we   = (state == BUSY) & latWe;
  assign bus.ram_addr = latAddr;
  assign bus.ram_wd   = latWd;

  assign bus.if_ack   = (state == ACK) & ~owner;
  assign bus.d_ack    = (state == ACK) & owner;
  assign bus.if_rdata = ifRdata;
  assign bus.d_rdata  = dRdata;

  assign bus.stall_req_if  = bus.if_req & ~bus.if_ack;
  assign bus.stall_req_mem = bus.d_req & ~bus.d_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance for most scenarios and
// a MEM_LAT=1 instance for back-to-back fetches, both against a small RAM model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nCmp = 0;
  int   nErr = 0;
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) b();
  mem_port_arbiter_if #(.AW(32), .DW(32)) b1();

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) dut  (.clk(clk), .rst(rst), .bus(b));
  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  // Word-addressed RAM model, read data valid while the address is presented.
  assign b.ram_rd  = mem[b.ram_addr[9:2]];
  assign b1.ram_rd = mem[b1.ram_addr[9:2]];
  always @(posedge clk) if (b.ram_ce && b.ram_we) mem[b.ram_addr[9:2]] = b.ram_wd;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b.if_req = 1'b1;
    #1;
    nCmp++; if (b.stall_req_if !== 1'b1) begin nErr++; $display("FAIL rst_stall_if: got %b want 1", b.stall_req_if); end
    nCmp++; if (b.if_ack !== 1'b0 || b.d_ack !== 1'b0) begin nErr++; $display("FAIL rst_acks: got %b%b want 00", b.if_ack, b.d_ack); end
    nCmp++; if (b.if_rdata !== 32'h0 || b.d_rdata !== 32'h0) begin nErr++; $display("FAIL rst_rdata: got %h/%h want 0/0", b.if_rdata, b.d_rdata); end
    nCmp++; if (b.ram_ce !== 1'b0 || b.ram_we !== 1'b0) begin nErr++; $display("FAIL rst_ram_ctl: got %b%b want 00", b.ram_ce, b.ram_we); end
    nCmp++; if (b.ram_addr !== 32'h0 || b.ram_wd !== 32'h0) begin nErr++; $display("FAIL rst_ram_bus: got %h/%h want 0/0", b.ram_addr, b.ram_wd); end
    repeat (2) cyc();
    b.if_req = 1'b0;
    rst = 1'b0;
    #1;
    nCmp++; if (b.stall_req_if !== 1'b0) begin nErr++; $display("FAIL rst_stall_drop: got %b want 0", b.stall_req_if); end
  endtask

  task automatic test_fetch();
    b.if_req = 1'b1; b.if_addr = 32'h10;
    #1;
    nCmp++; if (b.stall_req_if !== 1'b1 || b.ram_ce !== 1'b0) begin nErr++; $display("FAIL fetch_T: stall/ce got %b%b want 10", b.stall_req_if, b.ram_ce); end
    cyc();
    nCmp++; if (b.ram_ce !== 1'b1 || b.ram_we !== 1'b0 || b.ram_addr !== 32'h10) begin nErr++; $display("FAIL fetch_T1: ce/we/addr got %b%b/%h want 10/10", b.ram_ce, b.ram_we, b.ram_addr); end
    nCmp++; if (b.stall_req_if !== 1'b1 || b.if_ack !== 1'b0) begin nErr++; $display("FAIL fetch_T1_stall: stall/ack got %b%b want 10", b.stall_req_if, b.if_ack); end
    cyc();
    nCmp++; if (b.ram_ce !== 1'b1 || b.stall_req_if !== 1'b1) begin nErr++; $display("FAIL fetch_T2: ce/stall got %b%b want 11", b.ram_ce, b.stall_req_if); end
    cyc();
    nCmp++; if (b.if_ack !== 1'b1 || b.if_rdata !== 32'h2402_0005) begin nErr++; $display("FAIL fetch_T3_ack: ack/rdata got %b/%h want 1/24020005", b.if_ack, b.if_rdata); end
    nCmp++; if (b.stall_req_if !== 1'b0 || b.ram_ce !== 1'b0) begin nErr++; $display("FAIL fetch_T3_stall: stall/ce got %b%b want 00", b.stall_req_if, b.ram_ce); end
    b.if_req = 1'b0;
    cyc();
    nCmp++; if (b.if_ack !== 1'b0 || b.if_rdata !== 32'h2402_0005 || b.ram_addr !== 32'h10) begin nErr++; $display("FAIL fetch_hold: ack/rdata/addr got %b/%h/%h want 0/24020005/10", b.if_ack, b.if_rdata, b.ram_addr); end
  endtask

  task automatic test_write_read();
    b.d_req = 1'b1; b.d_we = 1'b1; b.d_addr = 32'h40; b.d_wdata = 32'hDEAD_BEEF;
    #1;
    nCmp++; if (b.ram_we !== 1'b0 || b.stall_req_mem !== 1'b1) begin nErr++; $display("FAIL wr_T: we/stall got %b%b want 01", b.ram_we, b.stall_req_mem); end
    cyc();
    nCmp++; if (b.ram_we !== 1'b1 || b.ram_addr !== 32'h40 || b.ram_wd !== 32'hDEAD_BEEF) begin nErr++; $display("FAIL wr_T1: we/addr/wd got %b/%h/%h want 1/40/deadbeef", b.ram_we, b.ram_addr, b.ram_wd); end
    cyc();
    nCmp++; if (b.ram_we !== 1'b1) begin nErr++; $display("FAIL wr_T2: we got %b want 1", b.ram_we); end
    cyc();
    nCmp++; if (b.d_ack !== 1'b1 || b.ram_we !== 1'b0 || b.stall_req_mem !== 1'b0) begin nErr++; $display("FAIL wr_T3: ack/we/stall got %b%b%b want 100", b.d_ack, b.ram_we, b.stall_req_mem); end
    nCmp++; if (b.d_rdata !== 32'h0) begin nErr++; $display("FAIL wr_rdata_kept: got %h want 0", b.d_rdata); end
    b.d_req = 1'b0;
    cyc();
    nCmp++; if (mem[16] !== 32'hDEAD_BEEF) begin nErr++; $display("FAIL wr_mem: got %h want deadbeef", mem[16]); end
    b.d_we = 1'b0; b.d_req = 1'b1;
    repeat (3) cyc();
    nCmp++; if (b.d_ack !== 1'b1 || b.d_rdata !== 32'hDEAD_BEEF) begin nErr++; $display("FAIL rd_back: ack/rdata got %b/%h want 1/deadbeef", b.d_ack, b.d_rdata); end
    b.d_req = 1'b0;
    cyc();
  endtask

  task automatic test_contention();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    nCmp++; if (b.d_rdata !== 32'h0) begin nErr++; $display("FAIL cont_rst_rdata: got %h want 0", b.d_rdata); end
    b.if_req = 1'b1; b.if_addr = 32'h10;
    b.d_req = 1'b1; b.d_we = 1'b0; b.d_addr = 32'h40;
    for (int k = 1; k <= 11; k++) begin
      logic expD, expI, expCe;
      cyc();
      expD  = (k == 3) || (k == 11);
      expI  = (k == 7);
      expCe = (k == 1) || (k == 2) || (k == 5) || (k == 6) || (k == 9) || (k == 10);
      nCmp++; if (b.d_ack !== expD || b.if_ack !== expI) begin nErr++; $display("FAIL cont_ack T+%0d: d/if got %b%b want %b%b", k, b.d_ack, b.if_ack, expD, expI); end
      nCmp++; if (b.ram_ce !== expCe) begin nErr++; $display("FAIL cont_ce T+%0d: got %b want %b", k, b.ram_ce, expCe); end
      if (k == 3) begin
        nCmp++; if (b.d_rdata !== 32'hDEAD_BEEF) begin nErr++; $display("FAIL cont_drdata: got %h want deadbeef", b.d_rdata); end
      end
      if (k == 7) begin
        nCmp++; if (b.if_rdata !== 32'h2402_0005) begin nErr++; $display("FAIL cont_ifrdata: got %h want 24020005", b.if_rdata); end
      end
    end
    b.if_req = 1'b0; b.d_req = 1'b0;
    cyc();
  endtask

  task automatic test_held_request();
    b.if_req = 1'b1; b.if_addr = 32'h10;
    repeat (3) cyc();
    nCmp++; if (b.if_ack !== 1'b1) begin nErr++; $display("FAIL held_ack: got %b want 1", b.if_ack); end
    cyc();
    nCmp++; if (b.if_ack !== 1'b0 || b.ram_ce !== 1'b0) begin nErr++; $display("FAIL held_no_reaccept: ack/ce got %b%b want 00", b.if_ack, b.ram_ce); end
    b.if_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      nCmp++; if (b.if_ack !== 1'b0 || b.ram_ce !== 1'b0) begin nErr++; $display("FAIL held_single %0d: ack/ce got %b%b want 00", k, b.if_ack, b.ram_ce); end
    end
  endtask

  task automatic test_reset_mid_write();
    b.d_req = 1'b1; b.d_we = 1'b1; b.d_addr = 32'h80; b.d_wdata = 32'h1234_5678;
    cyc();
    nCmp++; if (b.ram_we !== 1'b1) begin nErr++; $display("FAIL midrst_busy: we got %b want 1", b.ram_we); end
    rst = 1'b1;
    #1;
    nCmp++; if (b.ram_ce !== 1'b0 || b.ram_we !== 1'b0) begin nErr++; $display("FAIL midrst_async: ce/we got %b%b want 00", b.ram_ce, b.ram_we); end
    nCmp++; if (b.ram_addr !== 32'h0 || b.ram_wd !== 32'h0) begin nErr++; $display("FAIL midrst_bus: addr/wd got %h/%h want 0/0", b.ram_addr, b.ram_wd); end
    b.d_req = 1'b0; b.d_we = 1'b0;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      nCmp++; if (b.d_ack !== 1'b0 || b.ram_ce !== 1'b0) begin nErr++; $display("FAIL midrst_no_ack %0d: ack/ce got %b%b want 00", k, b.d_ack, b.ram_ce); end
    end
    nCmp++; if (mem[32] !== 32'hA5A5_0020) begin nErr++; $display("FAIL midrst_mem: got %h want a5a50020", mem[32]); end
    b.if_req = 1'b1; b.if_addr = 32'h10;
    b.d_req = 1'b1; b.d_addr = 32'h40;
    repeat (3) cyc();
    nCmp++; if (b.d_ack !== 1'b1 || b.if_ack !== 1'b0) begin nErr++; $display("FAIL midrst_first_grant: d/if got %b%b want 10", b.d_ack, b.if_ack); end
    b.if_req = 1'b0; b.d_req = 1'b0;
    cyc();
  endtask

  task automatic test_lat1();
    b1.if_req = 1'b1; b1.if_addr = 32'h0;
    cyc();
    nCmp++; if (b1.ram_ce !== 1'b1 || b1.ram_addr !== 32'h0) begin nErr++; $display("FAIL lat1_T1: ce/addr got %b/%h want 1/0", b1.ram_ce, b1.ram_addr); end
    cyc();
    nCmp++; if (b1.if_ack !== 1'b1 || b1.if_rdata !== 32'h1111_1111 || b1.stall_req_if !== 1'b0) begin nErr++; $display("FAIL lat1_ack0: ack/rdata/stall got %b/%h/%b want 1/11111111/0", b1.if_ack, b1.if_rdata, b1.stall_req_if); end
    b1.if_addr = 32'h4;
    cyc();
    nCmp++; if (b1.if_ack !== 1'b0 || b1.ram_ce !== 1'b0) begin nErr++; $display("FAIL lat1_idle: ack/ce got %b%b want 00", b1.if_ack, b1.ram_ce); end
    cyc();
    nCmp++; if (b1.ram_ce !== 1'b1 || b1.ram_addr !== 32'h4) begin nErr++; $display("FAIL lat1_T4: ce/addr got %b/%h want 1/4", b1.ram_ce, b1.ram_addr); end
    cyc();
    nCmp++; if (b1.if_ack !== 1'b1 || b1.if_rdata !== 32'h2222_2222) begin nErr++; $display("FAIL lat1_ack1: ack/rdata got %b/%h want 1/22222222", b1.if_ack, b1.if_rdata); end
    b1.if_req = 1'b0;
    cyc();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | i;
    mem[0]  = 32'h1111_1111;
    mem[1]  = 32'h2222_2222;
    mem[4]  = 32'h2402_0005;
    mem[16] = 32'h0;
    b.if_req = 1'b0; b.if_addr = '0; b.d_req = 1'b0; b.d_we = 1'b0; b.d_addr = '0; b.d_wdata = '0;
    b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
    test_reset();
    test_fetch();
    test_write_read();
    test_contention();
    test_held_request();
    test_reset_mid_write();
    test_lat1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
